data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the pipeline's data-memory interface. It services the single-word path (address, size, read/write strobes) and the 256-bit block path (block read/write strobes) that the core drives. Storage is a parameterised big-endian word array. Block transfers take a configurable access latency followed by an 8-beat internal transfer, and a ready/valid handshake brackets them. It replaces the behavioural memory model, so cache work can be exercised against realistic multi-cycle block latency.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words stored; power of two; index = Address_IN[31:2] mod DEPTH_WORDS.
- LATENCY, 4: wait cycles before block beats start; must be ≥1.

- CLOCK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- Address_IN  in  32  byte address; [4:0] ignored for block ops.
- Data_IN  in  32  word write data, right-justified (low DataSize bytes used).
- DataSize_IN  in  2  bytes per word access: 1, 2, 3; 0 means 4.
- MemRead_IN  in  1  word read request.
- MemWrite_IN  in  1  word write request.
- DataBlock_IN  in  256  block write data; word 0 (lowest address) in [255:224].
- MemBlockRead_IN  in  1  block read request.
- MemBlockWrite_IN  in  1  block write request.
- Data_OUT  out  32  word read data, requested bytes right-justified, zero-extended.
- DataBlock_OUT  out  256  block read data, same word order as DataBlock_IN.
- Ready_OUT  out  1  high in IDLE; requests are accepted only when high.
- BlockValid_OUT  out  1  one-cycle pulse: block op complete, DataBlock_OUT valid for reads.
- Error_OUT  out  1  one-cycle pulse: misaligned or dropped request.

## Operation
- Big-endian: byte offset 0 of a word is bits [31:24].
- A word access covers offsets Address_IN[1:0] to Address_IN[1:0]+n-1, where n = DataSize_IN (n = 4 when DataSize_IN is 0).
  - Crossing a word boundary (offset + n > 4) is illegal: no write occurs, Data_OUT is unchanged, Error_OUT pulses.
- Request priority in IDLE: MemBlockWrite_IN > MemBlockRead_IN > MemWrite_IN > MemRead_IN.
  - The winner is serviced. Any other asserted request is dropped and Error_OUT pulses.
- Word write: commits at the accepting edge. State stays IDLE.
- Word read: Data_OUT is registered at the accepting edge. State stays IDLE.
- Block op: Address_IN[31:5] is latched; for writes, DataBlock_IN is also latched. The FSM then runs:
  - IDLE → WAIT: counter loads LATENCY-1.
  - WAIT: decrement; at 0 go to XFER with beat = 0.
  - XFER: one word per cycle. Reads fill block word [beat]; writes store latched word [beat] to memory. Go to DONE when beat = 7.
  - DONE: BlockValid_OUT = 1; next state IDLE.
- All requests are ignored while Ready_OUT = 0. No error is raised and the requester must hold the request.
- Reset in any state: FSM returns to IDLE. A partially written block stays partially written. Memory contents are never cleared by reset.

## Timing
- Values after reset:
  - Ready_OUT = 1.
  - BlockValid_OUT = 0.
  - Error_OUT = 0.
  - Data_OUT = 0.
  - DataBlock_OUT = 0.
- Word read: data on Data_OUT in the cycle after the accepting edge; held until the next word read.
- Word write: read-after-write with no gap returns the new data.
- Block op accepted at edge t:
  - Ready_OUT falls after t.
  - BlockValid_OUT is high in cycle t+LATENCY+9.
  - Ready_OUT returns high the cycle after that.
  - Back-to-back block ops: one every LATENCY+10 cycles.
- DataBlock_OUT holds its value until the next block read completes.
- Wrap-around: the address index wraps modulo DEPTH_WORDS; the beat counter wraps only by leaving XFER.

## Structure
- Shared package mem_resp_pkg:
  - state enum {IDLE, WAIT, XFER, DONE}.
  - Size encodings SZ_BYTE = 1, SZ_HALF = 2, SZ_TRIPLE = 3, SZ_WORD = 0.
  - BLOCK_WORDS = 8.
- Sub-module mem_lane_decode (combinational):
  - Inputs: offset, size.
  - Outputs: 4-bit byte-enable mask, lane shift amount, misalign flag.
  - Used by both the read path and the write path.

## Test plan
- Word write 0xDEADBEEF to 0x100 (size 0), then byte read of 0x101 → Data_OUT = 0x000000AD one cycle later; no error.
- Halfword read at 0x103 → Error_OUT pulse; Data_OUT unchanged; memory unchanged.
- Block write 0x0…0x7 pattern at 0x200 with LATENCY = 4 → BlockValid_OUT at t+13. A word read of 0x21C then returns 0x00000007.
- Block read of 0x200 → DataBlock_OUT[255:224] = 0x0 and [31:0] = 0x7 when BlockValid_OUT pulses. A MemRead_IN held during busy is serviced only after Ready_OUT rises.
- Simultaneous MemBlockRead_IN and MemWrite_IN in IDLE → block read proceeds; word write is dropped with an Error_OUT pulse.
- Block write with RESET asserted during XFER beat 3 → IDLE next cycle with Ready_OUT = 1. Words 0–2 hold new data; words 3–7 keep their old data.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// DataSize encodings, block geometry and a byte-to-bit mask helper.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_WORD   = 2'd0;
    localparam logic [1:0] SZ_BYTE   = 2'd1;
    localparam logic [1:0] SZ_HALF   = 2'd2;
    localparam logic [1:0] SZ_TRIPLE = 2'd3;

    localparam int BLOCK_WORDS = 8;

    function automatic logic [31:0] expand_mask(input logic [3:0] byte_en);
        expand_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core <-> data-memory bus: single-word path, 256-bit block path and status.
interface data_mem_responder_if;

    logic [31:0]  Address_IN;
    logic [31:0]  Data_IN;
    logic [1:0]   DataSize_IN;
    logic         MemRead_IN;
    logic         MemWrite_IN;
    logic [255:0] DataBlock_IN;
    logic         MemBlockRead_IN;
    logic         MemBlockWrite_IN;
    logic [31:0]  Data_OUT;
    logic [255:0] DataBlock_OUT;
    logic         Ready_OUT;
    logic         BlockValid_OUT;
    logic         Error_OUT;

    modport master (
        output Address_IN, Data_IN, DataSize_IN, MemRead_IN, MemWrite_IN,
               DataBlock_IN, MemBlockRead_IN, MemBlockWrite_IN,
        input  Data_OUT, DataBlock_OUT, Ready_OUT, BlockValid_OUT, Error_OUT
    );

    modport slave (
        input  Address_IN, Data_IN, DataSize_IN, MemRead_IN, MemWrite_IN,
               DataBlock_IN, MemBlockRead_IN, MemBlockWrite_IN,
        output Data_OUT, DataBlock_OUT, Ready_OUT, BlockValid_OUT, Error_OUT
    );

endinterface

// File: rtl/mem_lane_decode.sv
// Big-endian lane decode for a word access: byte enables, right-justify shift
// (in bytes) and a flag for accesses that would cross a word boundary.
module mem_lane_decode
    import mem_resp_pkg::*;
(
    input  logic [1:0] offset,
    input  logic [1:0] size,
    output logic [3:0] byte_en,
    output logic [1:0] shift,
    output logic       misalign
);

    // byte_en[3] is offset 0 (bits [31:24]); every pair not listed crosses a word
    always_comb begin
        byte_en  = 4'b0000;
        shift    = 2'd0;
        misalign = 1'b0;
        case ({offset, size})
            {2'd0, SZ_BYTE}:   begin byte_en = 4'b1000; shift = 2'd3; end
            {2'd0, SZ_HALF}:   begin byte_en = 4'b1100; shift = 2'd2; end
            {2'd0, SZ_TRIPLE}: begin byte_en = 4'b1110; shift = 2'd1; end
            {2'd0, SZ_WORD}:   begin byte_en = 4'b1111; shift = 2'd0; end
            {2'd1, SZ_BYTE}:   begin byte_en = 4'b0100; shift = 2'd2; end
            {2'd1, SZ_HALF}:   begin byte_en = 4'b0110; shift = 2'd1; end
            {2'd1, SZ_TRIPLE}: begin byte_en = 4'b0111; shift = 2'd0; end
            {2'd2, SZ_BYTE}:   begin byte_en = 4'b0010; shift = 2'd1; end
            {2'd2, SZ_HALF}:   begin byte_en = 4'b0011; shift = 2'd0; end
            {2'd3, SZ_BYTE}:   begin byte_en = 4'b0001; shift = 2'd0; end
            default:           begin byte_en = 4'b0000; shift = 2'd0; misalign = 1'b1; end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: big-endian word array with single-cycle word access
// and latency-modelled 8-beat block transfers behind a Ready/BlockValid handshake.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4
) (
    input  logic                CLOCK,
    input  logic                RESET,
    data_mem_responder_if.slave bus
);

    localparam int AW     = $clog2(DEPTH_WORDS);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int BA_W   = AW - BEAT_W;
    localparam int CNT_W  = $clog2(LATENCY) + 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [BA_W-1:0]   blk_addr_q, blk_addr_d;
    logic              blk_write_q, blk_write_d;
    logic [255:0]      wblk_q, wblk_d;
    logic [255:0]      rblk_q, rblk_d;
    logic [255:0]      dblk_out_q, dblk_out_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];
    logic              mem_we_d;
    logic [AW-1:0]     mem_idx_d;
    logic [31:0]       mem_wdata_d;

    logic [3:0]        byte_en_s;
    logic [1:0]        shift_s;
    logic              misalign_s;
    logic [31:0]       lane_mask_s;
    logic [4:0]        lane_sh_s;
    logic [AW-1:0]     word_idx_s;
    logic [AW-1:0]     blk_idx_s;
    logic [31:0]       word_rd_s;
    logic [31:0]       blk_rd_s;
    logic              bw_s, br_s, w_s, r_s;
    logic              unused_addr_s;

    mem_lane_decode u_lane (
        .offset   (bus.Address_IN[1:0]),
        .size     (bus.DataSize_IN),
        .byte_en  (byte_en_s),
        .shift    (shift_s),
        .misalign (misalign_s)
    );

    assign bw_s          = bus.MemBlockWrite_IN;
    assign br_s          = bus.MemBlockRead_IN;
    assign w_s           = bus.MemWrite_IN;
    assign r_s           = bus.MemRead_IN;
    assign lane_mask_s   = expand_mask(byte_en_s);
    assign lane_sh_s     = {shift_s, 3'b000};
    assign word_idx_s    = bus.Address_IN[AW+1:2];
    assign blk_idx_s     = {blk_addr_q, beat_q};
    assign word_rd_s     = mem_q[word_idx_s];
    assign blk_rd_s      = mem_q[blk_idx_s];
    assign unused_addr_s = ^bus.Address_IN[31:AW+2];

    // Next-state, memory-port and output computation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        beat_d      = beat_q;
        blk_addr_d  = blk_addr_q;
        blk_write_d = blk_write_q;
        wblk_d      = wblk_q;
        rblk_d      = rblk_q;
        dblk_out_d  = dblk_out_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        mem_we_d    = 1'b0;
        mem_idx_d   = word_idx_s;
        mem_wdata_d = 32'd0;
        case (state_q)
            IDLE: begin
                if (bw_s || br_s) begin
                    state_d     = WAIT;
                    cnt_d       = CNT_W'(LATENCY - 1);
                    beat_d      = '0;
                    blk_addr_d  = bus.Address_IN[AW+1:5];
                    blk_write_d = bw_s;
                    err_d       = bw_s ? (br_s | w_s | r_s) : (w_s | r_s);
                    if (bw_s) begin
                        wblk_d = bus.DataBlock_IN;
                    end else begin
                        wblk_d = wblk_q;
                    end
                end else if (w_s) begin
                    err_d = misalign_s | r_s;
                    if (!misalign_s) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = (word_rd_s & ~lane_mask_s)
                                    | ((bus.Data_IN << lane_sh_s) & lane_mask_s);
                    end else begin
                        mem_we_d = 1'b0;
                    end
                end else if (r_s) begin
                    err_d = misalign_s;
                    if (!misalign_s) begin
                        data_out_d = (word_rd_s & lane_mask_s) >> lane_sh_s;
                    end else begin
                        data_out_d = data_out_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = XFER;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            XFER: begin
                // word [beat] lives at bits [32*(7-beat) +: 32], i.e. {~beat, 5'b0}
                mem_idx_d = blk_idx_s;
                if (blk_write_q) begin
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wblk_q[{~beat_q, 5'b00000} +: 32];
                end else begin
                    rblk_d[{~beat_q, 5'b00000} +: 32] = blk_rd_s;
                end
                if (beat_q == BEAT_W'(BLOCK_WORDS - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    if (!blk_write_q) begin
                        dblk_out_d = rblk_d;
                    end else begin
                        dblk_out_d = dblk_out_q;
                    end
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            blk_addr_q  <= '0;
            blk_write_q <= 1'b0;
            wblk_q      <= 256'd0;
            rblk_q      <= 256'd0;
            dblk_out_q  <= 256'd0;
            data_out_q  <= 32'd0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            blk_addr_q  <= blk_addr_d;
            blk_write_q <= blk_write_d;
            wblk_q      <= wblk_d;
            rblk_q      <= rblk_d;
            dblk_out_q  <= dblk_out_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
        end
    end

    // Storage array: never cleared, and a write in a reset cycle is discarded
    always_ff @(posedge CLOCK) begin
        if (mem_we_d && !RESET) begin
            mem_q[mem_idx_d] <= mem_wdata_d;
        end
    end

    assign bus.Data_OUT       = data_out_q;
    assign bus.DataBlock_OUT  = dblk_out_q;
    assign bus.Ready_OUT      = (state_q == IDLE);
    assign bus.BlockValid_OUT = valid_q;
    assign bus.Error_OUT      = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios plus random
// traffic, every cycle compared against a transaction-level reference model.
module tb_data_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLOCK (clk),
        .RESET (rst),
        .bus   (bus)
    );

    // Reference model: byte-addressed view of memory and block progress by age
    logic [31:0]  m_mem [DEPTH];
    logic [31:0]  e_data  = 32'd0;
    logic [255:0] e_blk   = 256'd0;
    logic         e_ready = 1'b1;
    logic         e_valid = 1'b0;
    logic         e_err   = 1'b0;
    bit           busy    = 1'b0;
    bit           b_wr    = 1'b0;
    bit           model_on = 1'b0;
    int           age     = 0;
    int           b_base  = 0;
    logic [255:0] b_data  = 256'd0;
    logic [255:0] b_fill  = 256'd0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_edge();
        int nreq, n, off, idx, k;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (rst) begin
            e_ready = 1'b1; e_data = 32'd0; e_blk = 256'd0; busy = 1'b0; model_on = 1'b1;
        end else if (busy) begin
            age++;
            if (age >= LAT + 1 && age <= LAT + 8) begin
                k   = age - LAT - 1;
                idx = (b_base + k) % DEPTH;
                if (b_wr) m_mem[idx] = b_data[255 - 32*k -: 32];
                else      b_fill[255 - 32*k -: 32] = m_mem[idx];
                if (k == 7) begin
                    e_valid = 1'b1;
                    if (!b_wr) e_blk = b_fill;
                end
            end else if (age == LAT + 9) begin
                busy    = 1'b0;
                e_ready = 1'b1;
            end
        end else begin
            nreq = int'(bus.MemBlockWrite_IN) + int'(bus.MemBlockRead_IN)
                 + int'(bus.MemWrite_IN) + int'(bus.MemRead_IN);
            e_err = (nreq > 1);
            n   = (bus.DataSize_IN == 2'd0) ? 4 : int'(bus.DataSize_IN);
            off = int'(bus.Address_IN[1:0]);
            idx = int'((bus.Address_IN >> 2) % DEPTH);
            if (bus.MemBlockWrite_IN || bus.MemBlockRead_IN) begin
                busy    = 1'b1;
                age     = 0;
                e_ready = 1'b0;
                b_wr    = bus.MemBlockWrite_IN;
                b_base  = int'(((bus.Address_IN >> 5) << 3) % DEPTH);
                b_data  = bus.DataBlock_IN;
            end else if (bus.MemWrite_IN || bus.MemRead_IN) begin
                if (off + n > 4) begin
                    e_err = 1'b1;
                end else if (bus.MemWrite_IN) begin
                    for (int i = 0; i < n; i++)
                        m_mem[idx][31 - 8*(off+i) -: 8] = bus.Data_IN[8*(n-1-i) +: 8];
                end else begin
                    e_data = 32'd0;
                    for (int i = 0; i < n; i++)
                        e_data = (e_data << 8) | {24'd0, m_mem[idx][31 - 8*(off+i) -: 8]};
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("Data_OUT",       256'(bus.Data_OUT),       256'(e_data));
        chk("DataBlock_OUT",  bus.DataBlock_OUT,        e_blk);
        chk("Ready_OUT",      256'(bus.Ready_OUT),      256'(e_ready));
        chk("BlockValid_OUT", 256'(bus.BlockValid_OUT), 256'(e_valid));
        chk("Error_OUT",      256'(bus.Error_OUT),      256'(e_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (model_on) compare_all();
    endtask

    task automatic clear();
        bus.Address_IN       = 32'd0;
        bus.Data_IN          = 32'd0;
        bus.DataSize_IN      = 2'd0;
        bus.MemRead_IN       = 1'b0;
        bus.MemWrite_IN      = 1'b0;
        bus.DataBlock_IN     = 256'd0;
        bus.MemBlockRead_IN  = 1'b0;
        bus.MemBlockWrite_IN = 1'b0;
    endtask

    task automatic word_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] sz);
        clear();
        bus.Address_IN  = a;
        bus.Data_IN     = d;
        bus.DataSize_IN = sz;
        bus.MemWrite_IN = wr;
        bus.MemRead_IN  = !wr;
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (bus.BlockValid_OUT !== 1'b1 && c < 64);
        chk(name, 256'(c), 256'(LAT + 8));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0]  r32;
        logic [31:0]  a;
        logic [255:0] blk;

        clear();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", 256'(bus.Ready_OUT),      256'(1'b1));
        chk("rst_valid", 256'(bus.BlockValid_OUT), 256'(1'b0));
        chk("rst_err",   256'(bus.Error_OUT),      256'(1'b0));
        chk("rst_data",  256'(bus.Data_OUT),       256'(32'd0));
        chk("rst_blk",   bus.DataBlock_OUT,        256'd0);

        // word write then byte read
        word_req(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'd0);
        tick();
        word_req(1'b0, 32'h0000_0101, 32'd0, 2'd1);
        tick();
        chk("byte_read",       256'(bus.Data_OUT),  256'(32'h0000_00AD));
        chk("byte_read_model", 256'(e_data),        256'(32'h0000_00AD));
        chk("byte_read_noerr", 256'(bus.Error_OUT), 256'(1'b0));

        // misaligned halfword read
        word_req(1'b0, 32'h0000_0103, 32'd0, 2'd2);
        tick();
        chk("misalign_err",  256'(bus.Error_OUT), 256'(1'b1));
        chk("misalign_hold", 256'(bus.Data_OUT),  256'(32'h0000_00AD));
        word_req(1'b0, 32'h0000_0100, 32'd0, 2'd0);
        tick();
        chk("misalign_mem", 256'(bus.Data_OUT), 256'(32'hDEAD_BEEF));

        // index wraps modulo DEPTH
        word_req(1'b1, 32'h1000_0102, 32'h0000_005A, 2'd1);
        tick();
        word_req(1'b0, 32'h0000_0100, 32'd0, 2'd0);
        tick();
        chk("wrap_write", 256'(bus.Data_OUT), 256'(32'hDEAD_5AEF));

        // block write 0..7 at 0x200
        clear();
        for (int k = 0; k < 8; k++) blk[255 - 32*k -: 32] = 32'(k);
        bus.Address_IN = 32'h0000_0200; bus.DataBlock_IN = blk; bus.MemBlockWrite_IN = 1'b1;
        tick();
        chk("bw_ready_fall", 256'(bus.Ready_OUT), 256'(1'b0));
        clear();
        wait_valid("bw_latency");
        tick();
        chk("bw_ready_back", 256'(bus.Ready_OUT), 256'(1'b1));
        word_req(1'b0, 32'h0000_021C, 32'd0, 2'd0);
        tick();
        chk("bw_word7", 256'(bus.Data_OUT), 256'(32'h0000_0007));

        // block read with a word read held while busy
        clear();
        bus.Address_IN = 32'h0000_0200; bus.MemBlockRead_IN = 1'b1;
        tick();
        word_req(1'b0, 32'h0000_0204, 32'd0, 2'd0);
        wait_valid("br_latency");
        chk("br_word0", 256'(bus.DataBlock_OUT[255:224]), 256'(32'h0));
        chk("br_word7", 256'(bus.DataBlock_OUT[31:0]),    256'(32'h7));
        chk("held_read_busy", 256'(bus.Data_OUT), 256'(32'h0000_0007));
        tick();
        chk("held_read_done", 256'(bus.Data_OUT), 256'(32'h0000_0007));
        tick();
        chk("held_read_served", 256'(bus.Data_OUT), 256'(32'h0000_0001));

        // block read beats a simultaneous word write
        word_req(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 2'd0);
        bus.MemBlockRead_IN = 1'b1;
        tick();
        chk("drop_err", 256'(bus.Error_OUT), 256'(1'b1));
        clear();
        wait_valid("drop_latency");
        chk("drop_blk0", 256'(bus.DataBlock_OUT[255:224]), 256'(32'h0));
        tick();
        word_req(1'b0, 32'h0000_0200, 32'd0, 2'd0);
        tick();
        chk("drop_no_write", 256'(bus.Data_OUT), 256'(32'h0));

        // reset during XFER beat 3 of a block write
        clear();
        for (int k = 0; k < 8; k++) blk[255 - 32*k -: 32] = 32'h1000_0000 | 32'(k);
        bus.Address_IN = 32'h0000_0200; bus.DataBlock_IN = blk; bus.MemBlockWrite_IN = 1'b1;
        tick();
        clear();
        repeat (LAT + 3) tick();
        rst = 1'b1;
        tick();
        chk("xfer_rst_ready", 256'(bus.Ready_OUT), 256'(1'b1));
        rst = 1'b0;
        word_req(1'b0, 32'h0000_0208, 32'd0, 2'd0);
        tick();
        chk("xfer_rst_w2", 256'(bus.Data_OUT), 256'(32'h1000_0002));
        word_req(1'b0, 32'h0000_020C, 32'd0, 2'd0);
        tick();
        chk("xfer_rst_w3", 256'(bus.Data_OUT), 256'(32'h0000_0003));

        // fill the random-traffic region (word indices 0..31)
        for (int b = 0; b < 4; b++) begin
            clear();
            for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
            bus.Address_IN = 32'(b * 32); bus.DataBlock_IN = blk; bus.MemBlockWrite_IN = 1'b1;
            tick();
            clear();
            wait_valid("init_latency");
            tick();
        end

        // random traffic, overlapping requests, misalignment and rare resets
        for (int c = 0; c < 800; c++) begin
            r32 = $urandom;
            a   = $urandom;
            a[11:7] = 5'd0;
            bus.Address_IN       = a;
            bus.Data_IN          = $urandom;
            bus.DataSize_IN      = r32[1:0];
            bus.MemRead_IN       = (r32[3:2] == 2'd0);
            bus.MemWrite_IN      = (r32[5:4] == 2'd0);
            bus.MemBlockRead_IN  = (r32[9:6] == 4'd0);
            bus.MemBlockWrite_IN = (r32[13:10] == 4'd0);
            for (int k = 0; k < 8; k++) blk[32*k +: 32] = $urandom;
            bus.DataBlock_IN     = blk;
            rst                  = (r32[23:16] == 8'd0);
            tick();
        end
        rst = 1'b0;
        clear();
        repeat (LAT + 12) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
